aig_bench_driver: RTL
=====================

Name: aig_bench_driver

Overview:
- Sequential stimulus/response engine that sits on the opposite side of a generated benchmark netlist's port list: it drives the 14 primary inputs (x0..x13) and consumes the 17 outputs (f1..f17).
- Generates a run of input vectors (incrementing counter or Galois LFSR) and compacts every returned output vector into a 32-bit MISR signature.
- Used to produce golden signatures for original vs. BALANCED/optimised variants of the same circuit.

Parameters:
- N_IN, 14, width of x_out (DUT primary inputs)
- N_OUT, 17, width of f_in (DUT primary outputs)
- DUT_LAT, 1, edges between driving a vector and sampling its response; range 1..4
- MISR_POLY, 32'h04C11DB7, MISR feedback polynomial
- LFSR_POLY, 14'h3802, Galois LFSR feedback mask for LFSR mode

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- mode  in  1  0 = counter, 1 = LFSR; captured at start
- seed  in  N_IN  first vector; captured at start
- num_patterns  in  N_IN+1  vector count, 0..2^N_IN; captured at start
- x_out  out  N_IN  registered vector to DUT x0..x(N_IN-1), bit i -> x_i
- f_in  in  N_OUT  DUT outputs f1..f(N_OUT), bit i <- f_(i+1)
- busy  out  1  high from the start edge until done
- done  out  1  one-cycle pulse when the signature is final
- signature  out  32  MISR value; stable while not busy

Behaviour:
- Reset:
  - state = IDLE; x_out = 0; busy = 0; done = 0; signature = 0.
  - Pattern counter and capture pipeline cleared.
  - Reset mid-run aborts immediately and applies the same values. No done pulse is generated.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - On an edge T0 with start = 1, latch mode and num_patterns.
  - Load x_out = seed, clear signature to 0, set busy = 1.
  - Go to RUN, or to FIN if num_patterns = 0.
  - In LFSR mode, seed = 0 is replaced with 1.
- RUN:
  - One new vector per edge; edges T0..T0+N-1 issue vectors 0..N-1, where N = num_patterns.
  - Counter mode: next = x_out + 1, modulo 2^N_IN (wraps 3FFF -> 0000).
  - LFSR mode: next = x_out[0] ? ((x_out >> 1) ^ LFSR_POLY) : (x_out >> 1).
  - After the last vector is issued, x_out holds its value and the state moves to DRAIN.
- Capture:
  - A valid shift pipe of depth DUT_LAT tags each issued vector.
  - f_in is sampled at edges T0+DUT_LAT .. T0+N-1+DUT_LAT, exactly N samples.
  - MISR update per sample: sig' = (sig << 1) ^ (sig[31] ? MISR_POLY : 0) ^ zero_extend(f_in).
- DRAIN: stays until the valid pipe is empty, then goes to FIN.
- FIN:
  - done = 1 for one cycle at edge T0+N+DUT_LAT (T0+1 when N = 0).
  - busy falls on the same edge; return to IDLE.
- start while busy is ignored, with no queueing.
- start asserted in the done cycle is accepted on the next edge.
- signature updates only on capture edges. It holds after done until the next accepted start.
- N = 2^N_IN in counter mode covers all vectors exactly once.

Test Plan:
- Counter mode, seed 0, N = 1, f_in = 0, DUT_LAT = 1 -> x_out = 0000 at T0; done at T0+2; signature = 0x00000000.
- Counter mode, N = 2, f_in held at 17'h1FFFF -> samples give 0x0001FFFF then 0x00020001; done at T0+3; busy high T0..T0+2.
- LFSR mode, seed 0, N = 4 -> x_out sequence 0001, 3802, 1C01, 3602; seed 0 is treated as 1.
- Counter mode, seed 3FFE, N = 3, DUT = identity (f_in = {3'b0, x_out}, combinational) -> captures 3FFE, 3FFF, 0000 (wrap); signature matches a software MISR reference.
- N = 0 -> done at T0+1, signature = 0. Separately, rst asserted mid-RUN -> x_out = 0, busy = 0, no done pulse; a following start runs normally.
- start pulsed during RUN -> ignored and counts unchanged. Separately, start asserted in the done cycle -> new run begins on the next edge with signature cleared.

Source files
------------

// File: rtl/aig_bench_driver.sv
// aig_bench_driver: drives a benchmark netlist with a run of input vectors
// (counter or Galois LFSR) and compacts the returned outputs into a 32-bit
// MISR signature for golden-signature comparison of netlist variants.
module aig_bench_driver #(
  parameter int              N_IN      = 14,
  parameter int              N_OUT     = 17,
  parameter int              DUT_LAT   = 1,
  parameter logic [31:0]     MISR_POLY = 32'h04C11DB7,
  parameter logic [N_IN-1:0] LFSR_POLY = 14'h3802
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [N_IN-1:0]   seed,
  input  logic [N_IN:0]     num_patterns,
  output logic [N_IN-1:0]   x_out,
  input  logic [N_OUT-1:0]  f_in,
  output logic              busy,
  output logic              done,
  output logic [31:0]       signature
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // One MISR step: shift, fold back the polynomial on carry-out, xor sample.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [N_OUT-1:0] smp);
    logic [31:0] fb;
    fb = sig[31] ? MISR_POLY : 32'h0000_0000;
    return (sig << 1) ^ fb ^ {{(32-N_OUT){1'b0}}, smp};
  endfunction

  logic [1:0]         state_q, state_d;
  logic [N_IN-1:0]    x_q, x_d;
  logic [N_IN:0]      rem_q, rem_d;      // vectors still to issue after the current one
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        sig_q, sig_d;
  logic [DUT_LAT-1:0] valid_q, valid_d;  // one tag per vector in flight through the DUT

  logic               issue_s;
  logic               cap_s;
  logic               drain_empty_s;     // pipe is empty after this edge if nothing is issued
  logic [N_IN-1:0]    next_x_s;
  logic [N_IN-1:0]    start_x_s;

  assign cap_s         = valid_q[DUT_LAT-1];
  assign drain_empty_s = ((valid_q << 1) == {DUT_LAT{1'b0}});

  // Next vector generator for the current run's mode.
  always_comb begin
    if (mode_q) begin
      next_x_s = x_q[0] ? ((x_q >> 1) ^ LFSR_POLY) : (x_q >> 1);
    end else begin
      next_x_s = x_q + {{(N_IN-1){1'b0}}, 1'b1};
    end
  end

  // First vector: an all-zero LFSR seed would lock up, so substitute 1.
  always_comb begin
    if (mode && (seed == {N_IN{1'b0}})) begin
      start_x_s = {{(N_IN-1){1'b0}}, 1'b1};
    end else begin
      start_x_s = seed;
    end
  end

  // Sequencer: start capture, vector issue, drain and completion.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue_s = 1'b0;
    sig_d   = cap_s ? misr_step(sig_q, f_in) : sig_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          x_d    = start_x_s;
          sig_d  = 32'h0000_0000;
          busy_d = 1'b1;
          if (num_patterns == {(N_IN+1){1'b0}}) begin
            rem_d   = {(N_IN+1){1'b0}};
            state_d = ST_FIN;
          end else begin
            rem_d   = num_patterns - {{N_IN{1'b0}}, 1'b1};
            issue_s = 1'b1;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rem_q != {(N_IN+1){1'b0}}) begin
          x_d     = next_x_s;
          issue_s = 1'b1;
          rem_d   = rem_q - {{N_IN{1'b0}}, 1'b1};
          if (rem_q == {{N_IN{1'b0}}, 1'b1}) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = drain_empty_s ? ST_FIN : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = drain_empty_s ? ST_FIN : ST_DRAIN;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    valid_d    = valid_q << 1;
    valid_d[0] = issue_s;
  end

  // State registers with synchronous reset; reset aborts any run silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= {N_IN{1'b0}};
      rem_q   <= {(N_IN+1){1'b0}};
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= 32'h0000_0000;
      valid_q <= {DUT_LAT{1'b0}};
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
      valid_q <= valid_d;
    end
  end

  assign x_out     = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;

endmodule
